// File: rtl/pcnn_seq_controller.sv
`default_nettype none
// ============================================================================
// Module   : pcnn_seq_controller
// Purpose  : Load/compute/output sequencer for the PCNN image datapath
// Revision : 1.0
// ============================================================================
module pcnn_seq_controller #(
    parameter int ROWS  = 8,
    parameter int COLS  = 8,
    parameter int KSIZE = 3,
    parameter int ITERS = 4,
    localparam int RW = (ROWS  > 1) ? $clog2(ROWS)  : 1,
    localparam int CW = (COLS  > 1) ? $clog2(COLS)  : 1,
    localparam int KW = (KSIZE > 1) ? $clog2(KSIZE) : 1,
    localparam int IW = (ITERS > 1) ? $clog2(ITERS) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          go,
    input  logic          abort,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          out_ready,
    output logic          out_valid,
    output logic          img_we,
    output logic          ker_we,
    output logic [RW-1:0] row,
    output logic [CW-1:0] col,
    output logic [KW-1:0] krow,
    output logic [KW-1:0] kcol,
    output logic          mac_clr,
    output logic          mac_en,
    output logic          res_we,
    output logic          bank,
    output logic [IW-1:0] iter,
    output logic          busy,
    output logic          done
);

    localparam logic [RW-1:0] c_row_last  = RW'(ROWS - 1);
    localparam logic [CW-1:0] c_col_last  = CW'(COLS - 1);
    localparam logic [KW-1:0] c_k_last    = KW'(KSIZE - 1);
    localparam logic [IW-1:0] c_iter_last = IW'(ITERS - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LDI  = 3'd1,
        S_LDK  = 3'd2,
        S_MCLR = 3'd3,
        S_MAC  = 3'd4,
        S_WB   = 3'd5,
        S_OUT  = 3'd6,
        S_DONE = 3'd7
    } state_t;

    state_t r_state;
    logic   r_ld_img;
    logic   r_ld_ker;

    // Load strobes follow the stream directly so a stalled beat writes nothing.
    assign in_ready = r_ld_img | r_ld_ker;
    assign img_we   = r_ld_img & in_valid;
    assign ker_we   = r_ld_ker & in_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_ld_img  <= 1'b0;
            r_ld_ker  <= 1'b0;
            row       <= '0;
            col       <= '0;
            krow      <= '0;
            kcol      <= '0;
            iter      <= '0;
            bank      <= 1'b0;
            mac_clr   <= 1'b0;
            mac_en    <= 1'b0;
            res_we    <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else if (abort) begin
            r_state   <= S_IDLE;
            r_ld_img  <= 1'b0;
            r_ld_ker  <= 1'b0;
            row       <= '0;
            col       <= '0;
            krow      <= '0;
            kcol      <= '0;
            iter      <= '0;
            bank      <= 1'b0;
            mac_clr   <= 1'b0;
            mac_en    <= 1'b0;
            res_we    <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (go) begin
                        r_state  <= S_LDI;
                        r_ld_img <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                S_LDI: begin
                    if (in_valid) begin
                        if (col == c_col_last) begin
                            col <= '0;
                            if (row == c_row_last) begin
                                row      <= '0;
                                r_ld_img <= 1'b0;
                                r_ld_ker <= 1'b1;
                                r_state  <= S_LDK;
                            end else begin
                                row <= row + 1'b1;
                            end
                        end else begin
                            col <= col + 1'b1;
                        end
                    end
                end
                S_LDK: begin
                    if (in_valid) begin
                        if (kcol == c_k_last) begin
                            kcol <= '0;
                            if (krow == c_k_last) begin
                                krow     <= '0;
                                iter     <= '0;
                                bank     <= 1'b0;
                                r_ld_ker <= 1'b0;
                                mac_clr  <= 1'b1;
                                r_state  <= S_MCLR;
                            end else begin
                                krow <= krow + 1'b1;
                            end
                        end else begin
                            kcol <= kcol + 1'b1;
                        end
                    end
                end
                S_MCLR: begin
                    mac_clr <= 1'b0;
                    mac_en  <= 1'b1;
                    r_state <= S_MAC;
                end
                S_MAC: begin
                    if (kcol == c_k_last) begin
                        kcol <= '0;
                        if (krow == c_k_last) begin
                            krow    <= '0;
                            mac_en  <= 1'b0;
                            res_we  <= 1'b1;
                            r_state <= S_WB;
                        end else begin
                            krow <= krow + 1'b1;
                        end
                    end else begin
                        kcol <= kcol + 1'b1;
                    end
                end
                S_WB: begin
                    res_we <= 1'b0;
                    if (col == c_col_last) begin
                        col <= '0;
                        if (row == c_row_last) begin
                            row <= '0;
                            // Bank is left pointing at the final pass for the output phase.
                            if (iter == c_iter_last) begin
                                out_valid <= 1'b1;
                                r_state   <= S_OUT;
                            end else begin
                                iter    <= iter + 1'b1;
                                bank    <= ~bank;
                                mac_clr <= 1'b1;
                                r_state <= S_MCLR;
                            end
                        end else begin
                            row     <= row + 1'b1;
                            mac_clr <= 1'b1;
                            r_state <= S_MCLR;
                        end
                    end else begin
                        col     <= col + 1'b1;
                        mac_clr <= 1'b1;
                        r_state <= S_MCLR;
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        if (col == c_col_last) begin
                            col <= '0;
                            if (row == c_row_last) begin
                                row       <= '0;
                                out_valid <= 1'b0;
                                done      <= 1'b1;
                                r_state   <= S_DONE;
                            end else begin
                                row <= row + 1'b1;
                            end
                        end else begin
                            col <= col + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    iter    <= '0;
                    bank    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pcnn_seq_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_pcnn_seq_controller
// Purpose  : Scoreboard bench for pcnn_seq_controller (4x3/k3/i2 and all-ones)
// Revision : 1.0
// ============================================================================
module tb_pcnn_seq_controller;

    localparam int AR = 4, AC = 3, AK = 3, AI = 2;
    localparam int ARW = (AR > 1) ? $clog2(AR) : 1;
    localparam int ACW = (AC > 1) ? $clog2(AC) : 1;
    localparam int AKW = (AK > 1) ? $clog2(AK) : 1;
    localparam int AIW = (AI > 1) ? $clog2(AI) : 1;

    localparam int K_IMG = 1, K_KER = 2, K_CLR = 3, K_MAC = 4, K_WB = 5, K_OUT = 6, K_DONE = 7;

    typedef struct packed {
        logic [2:0] kind;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] c;
        logic [7:0] d;
    } ev_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DUT A: 4x3 image, 3x3 kernel, 2 passes
    logic rstA, goA, abortA, ivA, orA;
    logic irdyA, ovA, imgA, kerA, clrA, enA, resA, bankA, busyA, doneA;
    logic [ARW-1:0] rowA;
    logic [ACW-1:0] colA;
    logic [AKW-1:0] krowA, kcolA;
    logic [AIW-1:0] iterA;

    // DUT B: every dimension 1
    logic rstB, goB, abortB, ivB, orB;
    logic irdyB, ovB, imgB, kerB, clrB, enB, resB, bankB, busyB, doneB;
    logic rowB, colB, krowB, kcolB, iterB;

    pcnn_seq_controller #(.ROWS(AR), .COLS(AC), .KSIZE(AK), .ITERS(AI)) u_dut_a (
        .clk(clk), .rst(rstA), .go(goA), .abort(abortA),
        .in_valid(ivA), .in_ready(irdyA), .out_ready(orA), .out_valid(ovA),
        .img_we(imgA), .ker_we(kerA), .row(rowA), .col(colA),
        .krow(krowA), .kcol(kcolA), .mac_clr(clrA), .mac_en(enA),
        .res_we(resA), .bank(bankA), .iter(iterA), .busy(busyA), .done(doneA)
    );

    pcnn_seq_controller #(.ROWS(1), .COLS(1), .KSIZE(1), .ITERS(1)) u_dut_b (
        .clk(clk), .rst(rstB), .go(goB), .abort(abortB),
        .in_valid(ivB), .in_ready(irdyB), .out_ready(orB), .out_valid(ovB),
        .img_we(imgB), .ker_we(kerB), .row(rowB), .col(colB),
        .krow(krowB), .kcol(kcolB), .mac_clr(clrB), .mac_en(enB),
        .res_we(resB), .bank(bankB), .iter(iterB), .busy(busyB), .done(doneB)
    );

    int checks = 0;
    int errors = 0;

    ev_t q0[$];
    ev_t q1[$];

    bit       mon_en[2]   = '{1'b1, 1'b1};
    bit       in_comp[2]  = '{1'b0, 1'b0};
    int       ccnt[2]     = '{0, 0};
    bit       prev_hs[2]  = '{1'b0, 1'b0};
    bit       prev_ov[2]  = '{1'b0, 1'b0};
    bit       prev_or[2]  = '{1'b0, 1'b0};
    bit       chk_busy[2] = '{1'b0, 1'b0};
    int       prev_row[2] = '{0, 0};
    int       prev_col[2] = '{0, 0};
    int       iv_mode[2]  = '{0, 0};
    int       or_mode[2]  = '{0, 0};

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", nm, got, exp);
        end
    endtask

    function automatic ev_t mk(input int kind, input int a, input int b, input int c, input int d);
        ev_t e;
        e.kind = 3'(kind);
        e.a    = 8'(a);
        e.b    = 8'(b);
        e.c    = 8'(c);
        e.d    = 8'(d);
        return e;
    endfunction

    task automatic push(input int d, input ev_t e);
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    // Reference model: the whole job as an ordered list of observable events.
    task automatic push_job(input int d, input int nr, input int nc, input int nk, input int ni);
        for (int r = 0; r < nr; r++)
            for (int c = 0; c < nc; c++) push(d, mk(K_IMG, r, c, 0, 0));
        for (int r = 0; r < nk; r++)
            for (int c = 0; c < nk; c++) push(d, mk(K_KER, r, c, 0, 0));
        for (int it = 0; it < ni; it++)
            for (int r = 0; r < nr; r++)
                for (int c = 0; c < nc; c++) begin
                    push(d, mk(K_CLR, r, c, it % 2, it));
                    for (int kr = 0; kr < nk; kr++)
                        for (int kc = 0; kc < nk; kc++) push(d, mk(K_MAC, kr, kc, r, c));
                    push(d, mk(K_WB, r, c, it % 2, it));
                end
        for (int r = 0; r < nr; r++)
            for (int c = 0; c < nc; c++) push(d, mk(K_OUT, r, c, (ni - 1) % 2, 0));
        push(d, mk(K_DONE, 0, 0, 0, 0));
    endtask

    task automatic mon(input int d, input logic irdy, input logic img, input logic ker,
                       input logic clr, input logic en, input logic res, input logic ov,
                       input logic ordy, input logic dn, input logic bsy, input logic bk,
                       input int row, input int col, input int krow, input int kcol,
                       input int iter, input int exp_comp);
        ev_t got;
        ev_t exp;
        bit  have_ev;
        bit  have_exp;
        int  nstb;
        if (!mon_en[d]) begin
            in_comp[d] = 0; prev_hs[d] = 0; prev_ov[d] = 0; prev_or[d] = 0; chk_busy[d] = 0;
            return;
        end
        nstb = int'(img) + int'(ker) + int'(clr) + int'(en) + int'(res) + int'(ov);
        chk($sformatf("dut%0d strobe_excl", d),
            int'(nstb > 1 || ((img | ker) && !irdy) || (irdy && (clr | en | res | ov))), 0);

        have_ev = 1'b1;
        if (img)            got = mk(K_IMG, row, col, 0, 0);
        else if (ker)       got = mk(K_KER, krow, kcol, 0, 0);
        else if (clr)       got = mk(K_CLR, row, col, int'(bk), iter);
        else if (en)        got = mk(K_MAC, krow, kcol, row, col);
        else if (res)       got = mk(K_WB, row, col, int'(bk), iter);
        else if (ov && ordy) got = mk(K_OUT, row, col, int'(bk), 0);
        else if (dn)        got = mk(K_DONE, 0, 0, 0, 0);
        else                have_ev = 1'b0;

        if (have_ev) begin
            have_exp = 1'b0;
            exp = '0;
            if (d == 0 && q0.size() > 0) begin exp = q0.pop_front(); have_exp = 1'b1; end
            if (d == 1 && q1.size() > 0) begin exp = q1.pop_front(); have_exp = 1'b1; end
            checks++;
            if (!have_exp || got != exp) begin
                errors++;
                $display("FAIL dut%0d event_seq: got k%0d(%0d,%0d,%0d,%0d) required k%0d(%0d,%0d,%0d,%0d)%s",
                         d, got.kind, got.a, got.b, got.c, got.d,
                         exp.kind, exp.a, exp.b, exp.c, exp.d, have_exp ? "" : " (none pending)");
            end
        end

        if (prev_ov[d] && !prev_or[d])
            chk($sformatf("dut%0d out_hold", d),
                int'(ov && row == prev_row[d] && col == prev_col[d]), 1);
        if (chk_busy[d]) chk($sformatf("dut%0d busy_after_done", d), int'(bsy), 0);
        if (dn) chk($sformatf("dut%0d done_latency", d), int'(prev_hs[d]), 1);

        if (!bsy) in_comp[d] = 0;
        else if (!in_comp[d] && clr) begin
            in_comp[d] = 1; ccnt[d] = 1;
        end else if (in_comp[d]) begin
            if (ov) begin
                chk($sformatf("dut%0d compute_cycles", d), ccnt[d], exp_comp);
                in_comp[d] = 0;
            end else ccnt[d]++;
        end

        prev_hs[d]  = ov && ordy;
        prev_ov[d]  = ov;
        prev_or[d]  = ordy;
        prev_row[d] = row;
        prev_col[d] = col;
        chk_busy[d] = dn;
    endtask

    always @(negedge clk)
        mon(0, irdyA, imgA, kerA, clrA, enA, resA, ovA, orA, doneA, busyA, bankA,
            int'(rowA), int'(colA), int'(krowA), int'(kcolA), int'(iterA), AI * AR * AC * (AK * AK + 2));

    always @(negedge clk)
        mon(1, irdyB, imgB, kerB, clrB, enB, resB, ovB, orB, doneB, busyB, bankB,
            int'(rowB), int'(colB), int'(krowB), int'(kcolB), int'(iterB), 3);

    // Stream-side stimulus, re-driven just after every rising edge.
    initial begin
        int cyc;
        cyc = 0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            ivA = (iv_mode[0] == 0) ? 1'b1 : (iv_mode[0] == 1) ? cyc[0] : 1'($urandom_range(0, 1));
            orA = (or_mode[0] == 0) ? 1'b1 : (or_mode[0] == 1) ? (cyc % 3 != 0) : 1'($urandom_range(0, 1));
            ivB = (iv_mode[1] == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            orB = (or_mode[1] == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        end
    end

    task automatic pulse_go(input int d);
        @(posedge clk);
        #1;
        if (d == 0) goA = 1'b1; else goB = 1'b1;
        @(posedge clk);
        #1;
        if (d == 0) goA = 1'b0; else goB = 1'b0;
    endtask

    task automatic start_job(input int d);
        if (d == 0) push_job(0, AR, AC, AK, AI);
        else        push_job(1, 1, 1, 1, 1);
        pulse_go(d);
        @(negedge clk);
        chk($sformatf("dut%0d in_ready_after_go", d), int'((d == 0) ? irdyA : irdyB), 1);
    endtask

    task automatic wait_done(input int d);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 5000 && !seen; i++) begin
            @(negedge clk);
            seen = (d == 0) ? doneA : doneB;
        end
        chk($sformatf("dut%0d done_seen", d), int'(seen), 1);
        @(negedge clk);
        chk($sformatf("dut%0d queue_drained", d), (d == 0) ? q0.size() : q1.size(), 0);
        if (d == 0) q0.delete(); else q1.delete();
    endtask

    task automatic run_job(input int d);
        start_job(d);
        wait_done(d);
    endtask

    task automatic abort_test();
        bit seen;
        start_job(0);
        seen = 1'b0;
        for (int i = 0; i < 5000 && !seen; i++) begin
            @(negedge clk);
            seen = enA && iterA == 1 && rowA == 2 && colA == 1 && krowA == 1;
        end
        chk("abort_target_reached", int'(seen), 1);
        abortA = 1'b1;
        @(posedge clk);
        #1;
        abortA = 1'b0;
        q0.delete();
        @(negedge clk);
        chk("abort busy", int'(busyA), 0);
        chk("abort counters", int'({rowA, colA, krowA, kcolA, iterA, bankA}), 0);
        chk("abort strobes", int'({enA, clrA, resA, ovA, irdyA, doneA}), 0);
        repeat (5) @(negedge clk);
        chk("abort stays idle", int'(busyA), 0);
    endtask

    task automatic reset_test();
        bit seen;
        start_job(0);
        seen = 1'b0;
        for (int i = 0; i < 5000 && !seen; i++) begin
            @(negedge clk);
            seen = ovA;
        end
        chk("rst_out_reached", int'(seen), 1);
        repeat (2) @(negedge clk);
        mon_en[0] = 1'b0;
        #2;
        rstA = 1'b0;
        #1;
        chk("async_rst out_valid", int'(ovA), 0);
        chk("async_rst busy", int'(busyA), 0);
        chk("async_rst counters", int'({rowA, colA, krowA, kcolA, iterA, bankA}), 0);
        chk("async_rst strobes", int'({irdyA, doneA, enA, clrA, resA}), 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rstA = 1'b1;
        repeat (5) @(negedge clk);
        chk("rst no self restart", int'(busyA | irdyA), 0);
        q0.delete();
        mon_en[0] = 1'b1;
    endtask

    initial begin
        rstA = 1'b0; goA = 1'b0; abortA = 1'b0;
        rstB = 1'b0; goB = 1'b0; abortB = 1'b0;
        #1;
        chk("reset A outputs", int'({irdyA, ovA, imgA, kerA, clrA, enA, resA, bankA, busyA, doneA}), 0);
        chk("reset A counters", int'({rowA, colA, krowA, kcolA, iterA}), 0);
        chk("reset B outputs", int'({irdyB, ovB, busyB, doneB, bankB, iterB}), 0);
        @(posedge clk);
        #1;
        rstA = 1'b1;
        rstB = 1'b1;

        run_job(0);

        iv_mode[0] = 1; or_mode[0] = 1;
        fork
            run_job(0);
            begin : g_glitch
                bit seen;
                seen = 1'b0;
                for (int i = 0; i < 3000 && !seen; i++) begin @(negedge clk); seen = kerA; end
                chk("glitch_wait_ldk", int'(seen), 1);
                pulse_go(0);
                seen = 1'b0;
                for (int i = 0; i < 3000 && !seen; i++) begin @(negedge clk); seen = ovA; end
                chk("glitch_wait_out", int'(seen), 1);
                pulse_go(0);
            end
        join

        iv_mode[0] = 2; or_mode[0] = 2;
        run_job(0);
        abort_test();
        run_job(0);

        iv_mode[0] = 0; or_mode[0] = 0;
        reset_test();
        iv_mode[0] = 2; or_mode[0] = 2;
        run_job(0);

        run_job(1);
        iv_mode[1] = 2; or_mode[1] = 2;
        run_job(1);
        run_job(1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pcnn_seq_controller.md
# pcnn_seq_controller

Parametrised sequencing controller for the PCNN image-processing datapath. It loads an image and a convolution kernel over a valid/ready stream, then runs ITERS passes of per-pixel multiply-accumulate with ping-pong result banks, and streams the final result out. Row, column, kernel and iteration counters are internal, so the datapath needs no end-of-count flags. It sits between the host stream interface and the image/kernel RAMs, MAC unit and result RAM.

## Interface
- ROWS, 8, image rows (≥1)
- COLS, 8, image columns (≥1)
- KSIZE, 3, kernel edge length, KSIZE×KSIZE taps (≥1)
- ITERS, 4, PCNN iteration passes (≥1)
- RW/CW/KW/IW, derived as max(1,$clog2(N)) for ROWS/COLS/KSIZE/ITERS, not overridable

- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- go  in  1  start request, sampled only in IDLE
- abort  in  1  synchronous abort, any state
- in_valid  in  1  load-stream beat valid
- in_ready  out  1  controller accepts a load beat
- out_ready  in  1  downstream accepts an output beat
- out_valid  out  1  output beat valid
- img_we  out  1  image RAM write strobe
- ker_we  out  1  kernel RAM write strobe
- row  out  RW  current pixel row address
- col  out  CW  current pixel column address
- krow  out  KW  current kernel row address
- kcol  out  KW  current kernel column address
- mac_clr  out  1  clear accumulator
- mac_en  out  1  accumulate one tap
- res_we  out  1  result RAM write strobe
- bank  out  1  result bank being written; read bank is ~bank
- iter  out  IW  current pass index
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse

## Operation
- States: IDLE, LDI, LDK, MCLR, MAC, WB, OUT, DONE.
- IDLE: all counters held at 0; go=1 -> LDI.
- LDI: in_ready=1; img_we = in_valid; each accepted beat advances col, wrapping 0 with row+1; beat at (ROWS-1,COLS-1) -> LDK, row/col cleared.
- LDK: in_ready=1; ker_we = in_valid; kcol/krow advance the same way; beat at (KSIZE-1,KSIZE-1) -> MCLR, kernel counters, iter and bank cleared.
- MCLR: mac_clr=1 for one cycle -> MAC.
- MAC: mac_en=1 every cycle; kcol/krow step one tap per cycle; after tap (KSIZE-1,KSIZE-1) -> WB, kernel counters cleared.
- WB: res_we=1 for one cycle at (row,col,bank); pixel counters advance; not last pixel -> MCLR; last pixel and iter<ITERS-1 -> iter+1, bank toggled, pixels cleared, -> MCLR; last pixel and iter=ITERS-1 -> OUT, pixels cleared.
- OUT: out_valid=1, row/col address bank of final pass; advance on out_valid&&out_ready; last beat accepted -> DONE.
- DONE: done=1 one cycle -> IDLE (no terminal lock-up state).
- abort=1 in any state: next state IDLE, all counters cleared, done not asserted; abort takes priority over every other transition, including go.
- go outside IDLE ignored. Strobes (img_we, ker_we, mac_*, res_we, out_valid, in_ready) are decoded from state only plus in_valid for write strobes; at most one of them asserted except in_ready with img_we/ker_we.
- Counters wrap only under the rules above; no counter exceeds N-1.

## Timing
- Reset (rst=0): state IDLE, every output 0, bank 0, iter 0; effective immediately, independent of clk.
- go sampled high in IDLE -> in_ready high the next cycle.
- In LDI/LDK, in_valid low stalls counters; no beat lost or duplicated.
- Per pixel: KSIZE²+2 cycles (MCLR + KSIZE² MAC + WB); compute phase = ITERS·ROWS·COLS·(KSIZE²+2) cycles.
- OUT with out_ready held high: ROWS·COLS cycles; out_ready low holds row/col and out_valid.
- done asserted exactly one cycle after the last output handshake; busy low the cycle after done.
- ROWS=COLS=KSIZE=ITERS=1 is legal: 1 load beat, 1 kernel beat, 3 compute cycles, 1 output beat.

## Test plan
- ROWS=4,COLS=3,KSIZE=3,ITERS=2, back-to-back load: 12 img_we then 9 ker_we with correct (row,col)/(krow,kcol) sequence; compute = 2·12·11 = 264 cycles; 12 res_we per pass, bank 0 then 1; 12 output beats from bank 1; done one pulse.
- Same config, in_valid toggling 1-0 during load and out_ready low every third cycle: identical address/write sequences, no skipped or repeated address, out_valid held while stalled.
- abort mid-MAC of pass 1 pixel (2,1): next cycle IDLE, busy=0, all counters 0, no done; subsequent go runs a full clean job.
- Asynchronous rst=0 during OUT between clock edges: outputs go 0 immediately; after release, go required to restart.
- All parameters 1: go -> LDI(1 beat) -> LDK(1 beat) -> MCLR, MAC, WB -> OUT(1 beat) -> DONE; done pulse exactly once.
- go pulsed during LDK and during OUT: no effect on sequence or counters.
